// File: rtl/instr_encoder_loader.sv
// RV32I instruction encoder and imem loader: packs decoded operations into
// 32-bit words and writes them to consecutive word addresses over req/ack.
module instr_encoder_loader #(
  parameter int DEPTH   = 256,
  parameter int AW      = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          in_class,
  input  logic [2:0]          in_funct3,
  input  logic                in_alt,
  input  logic [4:0]          in_rd,
  input  logic [4:0]          in_rs1,
  input  logic [4:0]          in_rs2,
  input  logic signed [20:0]  in_imm,
  output logic                imem_we,
  output logic [AW-1:0]       imem_addr,
  output logic [31:0]         imem_wdata,
  input  logic                imem_ack,
  output logic [AW:0]         count,
  output logic                full,
  output logic                err
);

  localparam int WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WW-1:0] TMO_LAST = WW'(TIMEOUT - 1);
  localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(DEPTH);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  typedef enum logic {IDLE, WRITE} state_t;

  state_t          state_q, state_d;
  logic [AW:0]     count_q;
  logic [WW-1:0]   wait_q;
  logic [31:0]     wdata_p1;
  logic            err_q;
  logic            load, bad, done, tmo;

  function automatic logic legal_op(input logic [2:0] cls, input logic [20:0] imm);
    logic ok;
    ok = (cls != 3'd7);
    // Branch and jump offsets are byte offsets that must be halfword aligned
    if ((cls == 3'd4 || cls == 3'd5) && imm[0])
      ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [31:0] encode(
    input logic [2:0]  cls,
    input logic [2:0]  f3,
    input logic        alt,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [20:0] imm
  );
    logic [31:0] w;
    w = 32'h0;
    case (cls)
      3'd0: w = {1'b0, alt, 5'b00000, rs2, rs1, f3, rd, OP_R};
      3'd1: begin
        // Shift-immediates carry funct7 in the upper immediate bits
        if (f3 == 3'b001 || f3 == 3'b101)
          w = {1'b0, alt, 5'b00000, imm[4:0], rs1, f3, rd, OP_I};
        else
          w = {imm[11:0], rs1, f3, rd, OP_I};
      end
      3'd2: w = {imm[11:0], rs1, 3'b010, rd, OP_LW};
      3'd3: w = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_SW};
      3'd4: w = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], OP_BEQ};
      3'd5: w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
      3'd6: w = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  assign full       = (count_q == DEPTH_C);
  assign count      = count_q;
  assign imem_addr  = count_q[AW-1:0];
  assign imem_wdata = wdata_p1;
  assign err        = err_q;

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    imem_we  = 1'b0;
    load     = 1'b0;
    bad      = 1'b0;
    done     = 1'b0;
    tmo      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = rst_n & ~full & ~clear;
        if (in_valid && in_ready) begin
          if (legal_op(in_class, in_imm)) begin
            load    = 1'b1;
            state_d = WRITE;
          end else begin
            bad = 1'b1;
          end
        end
      end
      WRITE: begin
        imem_we = 1'b1;
        if (imem_ack) begin
          done    = 1'b1;
          state_d = IDLE;
        end else if (wait_q == TMO_LAST) begin
          tmo     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage p1: encoded word and write-port control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      wait_q   <= '0;
      wdata_p1 <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= bad | tmo;
      if (load) begin
        wdata_p1 <= encode(in_class, in_funct3, in_alt, in_rd, in_rs1, in_rs2, in_imm);
        wait_q   <= '0;
      end else if (state_q == WRITE && !imem_ack && !tmo) begin
        wait_q <= wait_q + 1'b1;
      end
      if (done)
        count_q <= count_q + 1'b1;
      else if (state_q == IDLE && clear)
        count_q <= '0;
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: field-placement reference model
// compared every cycle, plus hand-computed instruction words.
module tb_instr_encoder_loader;

  localparam int DEPTH   = 4;
  localparam int AW      = 2;
  localparam int TIMEOUT = 15;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               clear = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [2:0]         in_class = '0;
  logic [2:0]         in_funct3 = '0;
  logic               in_alt = 1'b0;
  logic [4:0]         in_rd = '0;
  logic [4:0]         in_rs1 = '0;
  logic [4:0]         in_rs2 = '0;
  logic signed [20:0] in_imm = '0;
  logic               imem_we;
  logic [AW-1:0]      imem_addr;
  logic [31:0]        imem_wdata;
  logic               imem_ack = 1'b0;
  logic [AW:0]        count;
  logic               full;
  logic               err;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  instr_encoder_loader #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_class(in_class), .in_funct3(in_funct3), .in_alt(in_alt),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .imem_ack(imem_ack), .count(count), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] put(input logic [31:0] w, input int v, input int lo, input int n);
    logic [31:0] f;
    f = 32'(v & ((1 << n) - 1));
    return w | (f << lo);
  endfunction

  function automatic logic [31:0] model_enc(input int cls, input int f3, input int alt,
                                            input int rd, input int rs1, input int rs2, input int imm);
    int opc [7] = '{51, 19, 3, 35, 99, 111, 103};
    int fn;
    logic [31:0] w;
    fn = (cls <= 1) ? f3 : (cls <= 3) ? 2 : 0;
    w = put(32'h0, opc[cls], 0, 7);
    if (cls != 5) begin
      w = put(w, fn, 12, 3);
      w = put(w, rs1, 15, 5);
    end
    if (cls != 3 && cls != 4) w = put(w, rd, 7, 5);
    if (cls == 0 || cls == 3 || cls == 4) w = put(w, rs2, 20, 5);
    case (cls)
      0: w = put(w, alt, 30, 1);
      1: if (f3 == 1 || f3 == 5) begin
           w = put(w, imm, 20, 5);
           w = put(w, alt, 30, 1);
         end else w = put(w, imm, 20, 12);
      2, 6: w = put(w, imm, 20, 12);
      3: begin
           w = put(w, imm >> 5, 25, 7);
           w = put(w, imm, 7, 5);
         end
      4: begin
           w = put(w, imm >> 12, 31, 1);
           w = put(w, imm >> 5, 25, 6);
           w = put(w, imm >> 1, 8, 4);
           w = put(w, imm >> 11, 7, 1);
         end
      5: begin
           w = put(w, imm >> 20, 31, 1);
           w = put(w, imm >> 1, 21, 10);
           w = put(w, imm >> 11, 20, 1);
           w = put(w, imm >> 12, 12, 8);
         end
      default: ;
    endcase
    return w;
  endfunction

  // Reference model: a pending write, how long it has waited, words written
  bit          m_busy;
  int          m_wait;
  int          m_count;
  bit          m_err;
  logic [31:0] m_data;
  int          m_imm;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_wait = 0; m_count = 0; m_err = 0; m_data = '0;
    end else begin
      m_err = 0;
      if (m_busy) begin
        if (imem_ack) begin
          m_busy = 0;
          m_count++;
        end else if (m_wait + 1 >= TIMEOUT) begin
          m_busy = 0;
          m_err = 1;
        end else m_wait++;
      end else if (clear) begin
        m_count = 0;
      end else if (in_valid && m_count < DEPTH) begin
        m_imm = int'(in_imm);
        if (in_class == 3'd7 || ((in_class == 3'd4 || in_class == 3'd5) && m_imm[0])) m_err = 1;
        else begin
          m_busy = 1;
          m_wait = 0;
          m_data = model_enc(int'(in_class), int'(in_funct3), int'(in_alt), int'(in_rd),
                             int'(in_rs1), int'(in_rs2), m_imm);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", 32'(in_ready), 32'(rst_n && !m_busy && m_count < DEPTH && !clear));
      chk("imem_we", 32'(imem_we), 32'(m_busy));
      chk("imem_addr", 32'(imem_addr), 32'(m_count % (1 << AW)));
      chk("count", 32'(count), 32'(m_count));
      chk("full", 32'(full), 32'(m_count == DEPTH));
      chk("err", 32'(err), 32'(m_err));
      if (m_busy) chk("imem_wdata", imem_wdata, m_data);
    end
  end

  task automatic send(input int cls, input int f3, input int alt, input int rd,
                      input int rs1, input int rs2, input int imm);
    in_class = 3'(cls); in_funct3 = 3'(f3); in_alt = 1'(alt);
    in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2); in_imm = 21'(imm);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_ack();
    imem_ack = 1'b1;
    @(posedge clk); #1;
    imem_ack = 1'b0;
  endtask

  initial begin
    int n;
    #1 chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst we", 32'(imem_we), 32'd0);
    chk("rst count", 32'(count), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle ready", 32'(in_ready), 32'd1);

    send(1, 0, 0, 1, 0, 0, 5);
    chk("addi we", 32'(imem_we), 32'd1);
    chk("addi addr", 32'(imem_addr), 32'd0);
    chk("addi word", imem_wdata, 32'h00500093);
    do_ack();
    chk("count after addi", 32'(count), 32'd1);

    send(0, 0, 0, 3, 1, 2, 0);
    chk("add word", imem_wdata, 32'h002081B3);
    do_ack();
    send(0, 0, 1, 3, 1, 2, 0);
    chk("sub addr", 32'(imem_addr), 32'd2);
    chk("sub word", imem_wdata, 32'h402081B3);
    do_ack();
    send(3, 0, 0, 0, 1, 2, 8);
    chk("sw word", imem_wdata, 32'h0020A423);
    do_ack();
    chk("full", 32'(full), 32'd1);
    chk("full ready", 32'(in_ready), 32'd0);

    send(1, 0, 0, 1, 0, 0, 1);
    chk("no write when full", 32'(imem_we), 32'd0);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    chk("count after clear", 32'(count), 32'd0);

    send(4, 0, 0, 0, 1, 2, 8);
    chk("beq addr", 32'(imem_addr), 32'd0);
    chk("beq word", imem_wdata, 32'h00208463);
    do_ack();
    send(5, 0, 0, 1, 0, 0, 16);
    chk("jal word", imem_wdata, 32'h010000EF);
    do_ack();

    send(7, 0, 0, 1, 1, 1, 0);
    chk("class7 err", 32'(err), 32'd1);
    chk("class7 we", 32'(imem_we), 32'd0);
    send(4, 0, 0, 0, 1, 2, 3);
    chk("beq odd err", 32'(err), 32'd1);
    chk("beq odd count", 32'(count), 32'd2);
    send(5, 0, 0, 1, 0, 0, 7);
    chk("jal odd err", 32'(err), 32'd1);

    send(2, 0, 0, 5, 2, 0, -4);
    chk("lw word", imem_wdata, 32'hFFC12283);
    n = 0;
    while (imem_we && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
    chk("timeout cycles", 32'(n), 32'd15);
    chk("timeout err", 32'(err), 32'd1);
    chk("timeout addr", 32'(imem_addr), 32'd2);

    send(6, 0, 0, 1, 3, 0, 2047);
    do_ack();
    send(1, 5, 1, 4, 4, 0, 3);
    chk("srai word", imem_wdata, 32'h40325213);
    do_ack();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    send(4, 0, 0, 0, 5, 6, -8);
    do_ack();
    send(5, 0, 0, 2, 0, 0, -2048);
    do_ack();
    send(3, 0, 0, 0, 7, 8, 32'h1FFFF);
    do_ack();

    send(1, 0, 0, 2, 2, 0, 9);
    chk("pre-reset we", 32'(imem_we), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("reset drops we", 32'(imem_we), 32'd0);
    chk("reset count", 32'(count), 32'd0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready after reset", 32'(in_ready), 32'd1);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
